// File: rtl/vga_timing_monitor.sv
// Receive-side VGA timing checker: measures line/frame geometry from Hs/Vs/Blank,
// compares it with the expected mode, tracks lock and sums active pixels per frame.
module vga_timing_monitor #(
    parameter int unsigned H_TOTAL     = 104,
    parameter int unsigned H_ACTIVE    = 80,
    parameter int unsigned HS_WIDTH    = 12,
    parameter int unsigned V_TOTAL     = 88,
    parameter int unsigned V_ACTIVE    = 60,
    parameter int unsigned VS_WIDTH    = 4,
    parameter int unsigned LOCK_FRAMES = 2,
    parameter int unsigned TIMEOUT     = 4096
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        Hs,
    input  logic        Vs,
    input  logic        Blank,
    input  logic [1:0]  R,
    input  logic [1:0]  G,
    input  logic [1:0]  B,
    output logic [15:0] h_total,
    output logic [15:0] h_active,
    output logic [15:0] hs_width,
    output logic [15:0] v_total,
    output logic [15:0] v_active,
    output logic [15:0] vs_width,
    output logic [23:0] checksum,
    output logic        frame_done,
    output logic        mismatch,
    output logic        timeout,
    output logic        locked
);

    typedef enum logic [1:0] {SEARCH = 2'd0, MEASURE = 2'd1, LOCKED = 2'd2} state_t;

    state_t      r_state, w_state_n;
    logic [3:0]  r_match, w_match_n, w_match_inc;

    logic        r_s_hs, r_s_vs, r_s_blank, r_d_hs, r_d_vs;
    logic [5:0]  r_s_pix;
    logic [15:0] r_hc, r_ha, r_hw, r_vc, r_va, r_vw;
    logic [23:0] r_acc;

    logic        w_hs_edge, w_vs_edge, w_fd, w_to, w_mism;
    logic [15:0] w_line_total, w_vc_n, w_va_n, w_vw_n;
    logic [15:0] w_last_ht, w_last_ha, w_last_hw;
    logic [23:0] w_acc_n;

    function automatic logic [15:0] sat_inc(input logic [15:0] v, input logic en);
        return (en && v != 16'hFFFF) ? v + 16'd1 : v;
    endfunction

    // A saturated measurement is never a valid match, whatever the parameter.
    function automatic logic off(input logic [15:0] v, input int unsigned p);
        return (v != p[15:0]) || (&v);
    endfunction

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_s_hs    <= 1'b0;
            r_s_vs    <= 1'b0;
            r_s_blank <= 1'b0;
            r_s_pix   <= '0;
            r_d_hs    <= 1'b0;
            r_d_vs    <= 1'b0;
        end else begin
            r_s_hs    <= Hs;
            r_s_vs    <= Vs;
            r_s_blank <= Blank;
            r_s_pix   <= {R, G, B};
            r_d_hs    <= r_s_hs;
            r_d_vs    <= r_s_vs;
        end
    end

    assign w_hs_edge    = r_d_hs & ~r_s_hs;
    assign w_vs_edge    = r_d_vs & ~r_s_vs;
    assign w_line_total = sat_inc(r_hc, 1'b1);
    assign w_vc_n       = sat_inc(r_vc, w_hs_edge);
    assign w_va_n       = sat_inc(r_va, w_hs_edge && (r_ha != '0));
    assign w_vw_n       = sat_inc(r_vw, w_hs_edge && !r_s_vs);
    assign w_acc_n      = r_acc + (r_s_blank ? {18'd0, r_s_pix} : 24'd0);

    // A line closing in the Vs-edge cycle is the latest completed line for the check.
    assign w_last_ht = w_hs_edge ? w_line_total : h_total;
    assign w_last_ha = w_hs_edge ? r_ha : h_active;
    assign w_last_hw = w_hs_edge ? r_hw : hs_width;

    assign w_mism = off(w_last_ht, H_TOTAL)  | off(w_last_ha, H_ACTIVE) |
                    off(w_last_hw, HS_WIDTH) | off(w_vc_n, V_TOTAL)     |
                    off(w_va_n, V_ACTIVE)    | off(w_vw_n, VS_WIDTH);
    assign w_fd   = w_vs_edge && (r_state != SEARCH);
    assign w_to   = (r_hc == 16'(TIMEOUT)) && !w_hs_edge;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_hc     <= '0;
            r_ha     <= '0;
            r_hw     <= '0;
            h_total  <= '0;
            h_active <= '0;
            hs_width <= '0;
        end else if (w_hs_edge) begin
            h_total  <= w_line_total;
            h_active <= r_ha;
            hs_width <= r_hw;
            r_hc     <= '0;
            r_ha     <= {15'd0, r_s_blank};
            r_hw     <= {15'd0, ~r_s_hs};
        end else begin
            r_hc <= sat_inc(r_hc, 1'b1);
            r_ha <= sat_inc(r_ha, r_s_blank);
            r_hw <= sat_inc(r_hw, ~r_s_hs);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_vc     <= '0;
            r_va     <= '0;
            r_vw     <= '0;
            r_acc    <= '0;
            v_total  <= '0;
            v_active <= '0;
            vs_width <= '0;
            checksum <= '0;
        end else if (w_vs_edge) begin
            v_total  <= w_vc_n;
            v_active <= w_va_n;
            vs_width <= w_vw_n;
            checksum <= w_acc_n;
            r_vc     <= '0;
            r_va     <= '0;
            r_vw     <= '0;
            r_acc    <= '0;
        end else begin
            r_vc  <= w_vc_n;
            r_va  <= w_va_n;
            r_vw  <= w_vw_n;
            r_acc <= w_acc_n;
        end
    end

    always_comb begin
        w_state_n   = r_state;
        w_match_n   = r_match;
        w_match_inc = r_match + 4'd1;
        case (r_state)
            SEARCH: begin
                if (w_vs_edge) begin
                    w_state_n = MEASURE;
                    w_match_n = '0;
                end
            end
            MEASURE: begin
                if (w_fd) begin
                    if (w_mism) begin
                        w_match_n = '0;
                    end else begin
                        w_match_n = w_match_inc;
                        if (w_match_inc == 4'(LOCK_FRAMES)) w_state_n = LOCKED;
                    end
                end
            end
            LOCKED: begin
                if (w_fd && w_mism) begin
                    w_state_n = SEARCH;
                    w_match_n = '0;
                end
            end
            default: w_state_n = SEARCH;
        endcase
        if (w_to) begin
            w_state_n = SEARCH;
            w_match_n = '0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= SEARCH;
            r_match    <= '0;
            frame_done <= 1'b0;
            mismatch   <= 1'b0;
            timeout    <= 1'b0;
            locked     <= 1'b0;
        end else begin
            r_state    <= w_state_n;
            r_match    <= w_match_n;
            frame_done <= w_fd;
            mismatch   <= w_fd & w_mism;
            timeout    <= w_to;
            locked     <= (r_state == LOCKED);
        end
    end

endmodule

// File: tb/tb_vga_timing_monitor.sv
// Bench for vga_timing_monitor: table of frames drives the video port, expected
// per-frame results are queued at each closing Vs edge and checked on frame_done.
module tb_vga_timing_monitor;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        Hs = 1'b1, Vs = 1'b1, Blank = 1'b0;
    logic [1:0]  R = '0, G = '0, B = '0;
    logic [15:0] h_total, h_active, hs_width, v_total, v_active, vs_width;
    logic [23:0] checksum;
    logic        frame_done, mismatch, timeout, locked;

    always #5 clock = ~clock;

    vga_timing_monitor #(
        .H_TOTAL(104), .H_ACTIVE(80), .HS_WIDTH(12),
        .V_TOTAL(88), .V_ACTIVE(60), .VS_WIDTH(4),
        .LOCK_FRAMES(2), .TIMEOUT(4096)
    ) dut (
        .clock(clock), .reset_n(reset_n),
        .Hs(Hs), .Vs(Vs), .Blank(Blank), .R(R), .G(G), .B(B),
        .h_total(h_total), .h_active(h_active), .hs_width(hs_width),
        .v_total(v_total), .v_active(v_active), .vs_width(vs_width),
        .checksum(checksum), .frame_done(frame_done), .mismatch(mismatch),
        .timeout(timeout), .locked(locked)
    );

    typedef struct {
        int htot; int nlines; int pat; bit fd; bit mism; bit lock; int cks;
    } vec_t;

    typedef struct {
        int h_total; int h_active; int hs_width;
        int v_total; int v_active; int vs_width;
        int cks; bit mism; bit lock;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass = 0;
    int   to_count = 0;
    bit   lock_pend = 1'b0, lock_exp = 1'b0, to_pend = 1'b0;

    task automatic chk(input string name, input longint act, input longint expv);
        n_checks++;
        if (act == expv) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, expv);
    endtask

    // Stimulus builds every line as: Hs low 0..11, Blank high 16..95, so 80/12 are fixed.
    function automatic exp_t make_exp(input vec_t v);
        exp_t e;
        e.h_total  = v.htot;
        e.h_active = 80;
        e.hs_width = 12;
        e.v_total  = v.nlines;
        e.v_active = (v.nlines > 60) ? 60 : v.nlines;
        e.vs_width = 4;
        e.cks      = v.cks;
        e.mism     = v.mism;
        e.lock     = v.lock;
        return e;
    endfunction

    task automatic cyc(input logic hs, input logic vs, input logic bl, input logic [1:0] lvl);
        Hs = hs; Vs = vs; Blank = bl;
        if (bl) begin
            R = lvl; G = lvl; B = lvl;
        end else begin
            R = 2'($urandom_range(3)); G = 2'($urandom_range(3)); B = 2'($urandom_range(3));
        end
        @(posedge clock); #1;
    endtask

    task automatic drive_line(input int htot, input bit vs_low, input bit act, input int pat);
        logic       bl;
        logic [1:0] lvl;
        for (int c = 0; c < htot; c++) begin
            bl  = act && (c >= 16) && (c < 96);
            lvl = (pat == 0) ? 2'd3 : 2'(((c - 16) / 20) & 3);
            cyc(c >= 12, !vs_low, bl, lvl);
        end
    endtask

    // Active lines sit at the end of the frame so the closing line carries video.
    task automatic drive_lines(input int htot, input int nlines, input int pat,
                               input int first, input int last);
        int act_start;
        act_start = (nlines > 60) ? nlines - 60 : 0;
        for (int l = first; l <= last; l++)
            drive_line(htot, l < 4, l >= act_start, pat);
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (lock_pend) begin
                chk("locked_after_frame", locked, lock_exp);
                lock_pend = 1'b0;
            end
            if (to_pend) begin
                chk("locked_after_timeout", locked, 0);
                to_pend = 1'b0;
            end
            if (timeout) begin
                to_count++;
                to_pend = 1'b1;
            end
            if (frame_done) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_frame_done: got 1, expected 0");
                end else begin
                    e = exp_q.pop_front();
                    chk("h_total",  h_total,  e.h_total);
                    chk("h_active", h_active, e.h_active);
                    chk("hs_width", hs_width, e.hs_width);
                    chk("v_total",  v_total,  e.v_total);
                    chk("v_active", v_active, e.v_active);
                    chk("vs_width", vs_width, e.vs_width);
                    chk("checksum", checksum, e.cks);
                    chk("mismatch", mismatch, e.mism);
                    lock_pend = 1'b1;
                    lock_exp  = e.lock;
                end
            end else if (mismatch) begin
                n_checks++;
                $display("FAIL stray_mismatch: got 1, expected 0");
            end
        end
    end

    initial begin
        vec_t tbl[7];
        vec_t vs;
        // htot, nlines, pattern(0 white, 1 bars), frame_done, mismatch, locked after, checksum
        tbl[0] = '{104, 88, 0, 1'b1, 1'b0, 1'b0, 302400};
        tbl[1] = '{104, 88, 0, 1'b1, 1'b0, 1'b1, 302400};
        tbl[2] = '{104, 88, 1, 1'b1, 1'b0, 1'b1, 151200};
        tbl[3] = '{105, 88, 0, 1'b1, 1'b1, 1'b0, 302400};
        tbl[4] = '{104,  8, 0, 1'b0, 1'b0, 1'b0, 0};
        tbl[5] = '{104, 88, 0, 1'b1, 1'b0, 1'b0, 302400};
        tbl[6] = '{104, 88, 0, 1'b1, 1'b0, 1'b1, 302400};

        repeat (3) @(posedge clock);
        #1;
        chk("reset_h_outputs", h_total | h_active | hs_width, 0);
        chk("reset_v_outputs", v_total | v_active | vs_width, 0);
        chk("reset_checksum", checksum, 0);
        chk("reset_flags", {frame_done, mismatch, timeout, locked}, 0);
        reset_n = 1'b1;
        repeat (4) cyc(1'b1, 1'b1, 1'b0, 2'd0);

        for (int i = 0; i < 7; i++) begin
            if (i > 0 && tbl[i-1].fd) exp_q.push_back(make_exp(tbl[i-1]));
            drive_lines(tbl[i].htot, tbl[i].nlines, tbl[i].pat, 0, tbl[i].nlines - 1);
        end
        exp_q.push_back(make_exp(tbl[6]));
        drive_line(104, 1'b1, 1'b0, 0);

        repeat (5000) cyc(1'b1, 1'b1, 1'b0, 2'd0);
        chk("timeout_pulses", to_count, 1);
        chk("locked_after_hold", locked, 0);

        // After the timeout the FSM searches: this frame's opening edge yields no frame_done.
        drive_lines(104, 10, 0, 0, 9);
        vs = '{104, 10, 0, 1'b1, 1'b1, 1'b0, 50400};
        exp_q.push_back(make_exp(vs));
        drive_lines(104, 10, 0, 0, 4);
        #2 reset_n = 1'b0;
        #1;
        chk("async_reset_h", h_total | h_active | hs_width, 0);
        chk("async_reset_v", v_total | v_active | vs_width, 0);
        chk("async_reset_checksum", checksum, 0);
        chk("async_reset_flags", {frame_done, mismatch, timeout, locked}, 0);
        drive_lines(104, 10, 0, 5, 5);
        reset_n = 1'b1;
        drive_lines(104, 10, 0, 6, 9);
        drive_lines(104, 10, 0, 0, 9);
        exp_q.push_back(make_exp(vs));
        drive_line(104, 1'b1, 1'b0, 0);
        repeat (20) cyc(1'b1, 1'b1, 1'b0, 2'd0);

        chk("queue_drained", exp_q.size(), 0);
        chk("timeout_total", to_count, 1);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
